fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the PC register and runs a request/ready handshake to instruction memory.
- Latches the returned instruction and presents the decoded fields (op, funct3, funct7b5) to the controller until the datapath signals completion.
- Consumes PCSrc and PCTarget from the controller/datapath to choose the next PC; traps on a misaligned target.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that sits in front of the single-cycle
// controller/datapath. It owns the PC and runs a req/ready handshake to
// instruction memory. It holds the fetched instruction and its decoded
// fields until the datapath retires it, then selects the next PC.
// A misaligned next PC parks the unit in a sticky TRAP state.
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a fetch that
// waits too long traps with cause 2. When it is undefined, fetch waits forever.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        exec_done,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE     = 2'd0;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        req_q;
    logic        trap_q;
    logic [1:0]  cause_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] pc_next_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] tmo_cnt_q;
`endif

    // Sequential PC successor and the PC that retirement would commit.
    always_comb begin
        pc_plus4_d = pc_q + 32'd4;
        pc_next_d  = PCSrc ? PCTarget : pc_plus4_d;
    end

    // Fetch/hold/trap controller. All outputs are registered here.
    // After reset, the first FETCH cycle only raises the request. Later
    // entries into FETCH from HOLD raise it on the same edge, which keeps
    // the loop at two cycles per instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ready) begin
                        // Ready wins over a timeout in the same cycle.
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_HOLD;
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                        state_q <= S_TRAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_HOLD: begin
                    if (exec_done) begin
                        valid_q <= 1'b0;
                        if (pc_next_d[1:0] != 2'b00) begin
                            // PC keeps pointing at the instruction that faulted.
                            trap_q  <= 1'b1;
                            cause_q <= CAUSE_MISALIGN;
                            state_q <= S_TRAP;
                        end else begin
                            pc_q    <= pc_next_d;
                            req_q   <= 1'b1;
                            state_q <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                S_TRAP: begin
                    // Frozen until reset.
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= S_TRAP;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4_d;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The bench keeps the architectural PC in m_pc. It answers fetch requests
// with random wait states and random words. It checks the handshake, the
// held fields, PC sequencing, trap behaviour and reset.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .exec_done(exec_done), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .instr_valid(instr_valid), .Instr(Instr), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .PC(PC), .PCPlus4(PCPlus4),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc",    PC, RST_PC);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_trap",  32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        step();
        reset = 1'b0;
        m_pc  = RST_PC;
        chk("req_after_rst", 32'(imem_req), 32'd0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic hold_check();
        chk("h_valid",  32'(instr_valid), 32'd1);
        chk("h_req",    32'(imem_req), 32'd0);
        chk("h_instr",  Instr, m_instr);
        chk("h_op",     32'(op), 32'(m_instr[6:0]));
        chk("h_f3",     32'(funct3), 32'(m_instr[14:12]));
        chk("h_f7b5",   32'(funct7b5), 32'(m_instr[30]));
        chk("h_pc",     PC, m_pc);
        chk("h_pcp4",   PCPlus4, m_pc + 32'd4);
        chk("h_trap",   32'(trap), 32'd0);
    endtask

    // Serve one fetch. Ready is held low for dly request cycles, then the
    // word is returned.
    task automatic fetch(input int dly, input logic [31:0] word);
        bit ok;
        wait_req(ok);
        chk("req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        for (int i = 0; i < dly; i++) begin
            exec_done = 1'($urandom);
            PCSrc     = 1'($urandom);
            PCTarget  = $urandom;
            chk("w_req",   32'(imem_req), 32'd1);
            chk("w_addr",  imem_addr, m_pc);
            chk("w_valid", 32'(instr_valid), 32'd0);
            chk("w_trap",  32'(trap), 32'd0);
            step();
        end
        exec_done  = 1'b0;
        chk("f_addr", imem_addr, m_pc);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        hold_check();
    endtask

    // Retire the held instruction after idle HOLD cycles.
    task automatic retire(input int idle, input bit src, input logic [31:0] tgt);
        logic [31:0] nxt;
        for (int i = 0; i < idle; i++) begin
            exec_done = 1'b0;
            PCSrc     = 1'($urandom);
            PCTarget  = $urandom;
            step();
            hold_check();
        end
        PCSrc     = src;
        PCTarget  = tgt;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        PCSrc     = 1'($urandom);
        PCTarget  = $urandom;
        nxt = src ? tgt : m_pc + 32'd4;
        if (nxt[1:0] != 2'b00) begin
            chk("mis_trap",  32'(trap), 32'd1);
            chk("mis_cause", 32'(trap_cause), 32'd1);
            chk("mis_pc",    PC, m_pc);
            chk("mis_valid", 32'(instr_valid), 32'd0);
            chk("mis_req",   32'(imem_req), 32'd0);
        end else begin
            m_pc = nxt;
            chk("r_valid", 32'(instr_valid), 32'd0);
            chk("r_req",   32'(imem_req), 32'd1);
            chk("r_addr",  imem_addr, m_pc);
            chk("r_trap",  32'(trap), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] t;
        bit          s;
        bit          ok;
        int          d;
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        step();
        do_reset();

        // Zero-wait fetch of addi x1,x0,5, then sequential retire.
        fetch(0, 32'h0050_0093);
        chk("op_addi", 32'(op), 32'h13);
        chk("f3_addi", 32'(funct3), 32'd0);
        retire(1, 1'b0, 32'h0);
        chk("seq_addr", imem_addr, 32'h4);

        // Slow memory, then a taken branch to 0x40.
        fetch(5, $urandom);
        retire(0, 1'b1, 32'h40);
        fetch(0, $urandom);
        chk("br_pc",   PC, 32'h40);
        chk("br_pcp4", PCPlus4, 32'h44);

        // PC wrap at the top of the address space.
        retire(2, 1'b1, 32'hFFFF_FFFC);
        fetch(1, $urandom);
        chk("wrap_pcp4", PCPlus4, 32'h0);
        retire(0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomized aligned traffic.
        for (int n = 0; n < 30; n++) begin
            d = int'($urandom_range(0, 4));
            w = $urandom;
            s = 1'($urandom_range(0, 1));
            t = $urandom & 32'hFFFF_FFFC;
            fetch(d, w);
            retire(int'($urandom_range(0, 2)), s, t);
        end

`ifndef FETCH_TIMEOUT_EN
        // No timeout: a long wait still completes normally.
        fetch(40, $urandom);
        retire(0, 1'b0, 32'h0);
`endif

        // Misaligned target traps, and the trap is sticky.
        fetch(0, $urandom);
        retire(0, 1'b1, 32'h42);
        exec_done  = 1'b1;
        PCSrc      = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_trap",  32'(trap), 32'd1);
            chk("frz_cause", 32'(trap_cause), 32'd1);
            chk("frz_pc",    PC, m_pc);
            chk("frz_req",   32'(imem_req), 32'd0);
            chk("frz_valid", 32'(instr_valid), 32'd0);
        end
        exec_done  = 1'b0;
        imem_ready = 1'b0;

        // Reset clears the trap. A mid-FETCH reset drops the request at once.
        do_reset();
        wait_req(ok);
        chk("req_seen2", 32'(ok), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

`ifdef FETCH_TIMEOUT_EN
        // Ready on the 16th request cycle still wins.
        fetch(15, $urandom);
        retire(0, 1'b0, 32'h0);
        // Ready never arrives: timeout trap after 16 request cycles.
        wait_req(ok);
        chk("req_seen3", 32'(ok), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("tmo_wait", 32'(trap), 32'd0);
            step();
        end
        chk("tmo_trap",  32'(trap), 32'd1);
        chk("tmo_cause", 32'(trap_cause), 32'd2);
        chk("tmo_req",   32'(imem_req), 32'd0);
        chk("tmo_pc",    PC, m_pc);
`else
        fetch(2, $urandom);
        retire(0, 1'b0, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
